reg_cmd_ctrl: RTL and testbench

Command front-end that sits directly upstream of the register file. It turns the received-byte stream from the UART receiver into register-file write and read strobes, and forwards each read result to the UART transmitter with a valid/busy handshake. Protocol: write = {WR_CMD, addr, data}; read = {RD_CMD, addr}, which returns one byte.

---
 rtl/reg_cmd_ctrl_if.sv | 31 +++
 rtl/reg_cmd_ctrl.sv | 139 +++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_ctrl_if.sv
// Bus bundle between the command front-end and its neighbours: UART RX/TX and the register file.
// All *_VLD, *En and CMD_ERR lines are single-cycle strobes; TX_D_VLD is issued only after TX_BUSY was sampled low.
interface reg_cmd_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  RX_P_DATA;
    logic              RX_D_VLD;
    logic [WIDTH-1:0]  RdData;
    logic              RdData_Valid;
    logic              TX_BUSY;
    logic              WrEn;
    logic              RdEn;
    logic [ADDR_W-1:0] Address;
    logic [WIDTH-1:0]  WrData;
    logic [WIDTH-1:0]  TX_P_DATA;
    logic              TX_D_VLD;
    logic              CMD_ERR;

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport master (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command parser: {WR_CMD, addr, data} writes a register, {RD_CMD, addr} reads one
// and forwards the result to the UART transmitter. Protocol errors raise a one-cycle CMD_ERR.
module reg_cmd_ctrl #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 16,
    parameter logic [WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int               RD_TIMEOUT = 4
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    reg_cmd_ctrl_if.slave        bus,
    output logic [2:0]           state_dbg
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pend_addr;
    logic [CNT_W-1:0]  cnt;
    logic              addr_bad;

    assign addr_bad  = (bus.RX_P_DATA[WIDTH-1:ADDR_W] != '0);
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state         <= IDLE;
            pend_addr     <= '0;
            cnt           <= '0;
            bus.WrEn      <= 1'b0;
            bus.RdEn      <= 1'b0;
            bus.Address   <= '0;
            bus.WrData    <= '0;
            bus.TX_P_DATA <= '0;
            bus.TX_D_VLD  <= 1'b0;
            bus.CMD_ERR   <= 1'b0;
        end else begin
            bus.WrEn     <= 1'b0;
            bus.RdEn     <= 1'b0;
            bus.TX_D_VLD <= 1'b0;
            bus.CMD_ERR  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == WR_CMD) begin
                            state <= WR_ADDR;
                        end else if (bus.RX_P_DATA == RD_CMD) begin
                            state <= RD_ADDR;
                        end else begin
                            bus.CMD_ERR <= 1'b1;
                        end
                    end
                end

                WR_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        if (addr_bad) begin
                            bus.CMD_ERR <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            pend_addr <= bus.RX_P_DATA[ADDR_W-1:0];
                            state     <= WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= pend_addr;
                        bus.WrData  <= bus.RX_P_DATA;
                        bus.WrEn    <= 1'b1;
                        state       <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (bus.RX_D_VLD) begin
                        if (addr_bad) begin
                            bus.CMD_ERR <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            pend_addr   <= bus.RX_P_DATA[ADDR_W-1:0];
                            bus.Address <= bus.RX_P_DATA[ADDR_W-1:0];
                            bus.RdEn    <= 1'b1;
                            cnt         <= '0;
                            state       <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (bus.RX_D_VLD) begin
                        bus.CMD_ERR <= 1'b1;
                    end
                    // The RdEn cycle itself is not counted toward the timeout.
                    if (bus.RdData_Valid) begin
                        bus.TX_P_DATA <= bus.RdData;
                        if (!bus.TX_BUSY) begin
                            bus.TX_D_VLD <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state <= TX_SEND;
                        end
                    end else if (!bus.RdEn) begin
                        if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                            bus.CMD_ERR <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                TX_SEND: begin
                    if (bus.RX_D_VLD) begin
                        bus.CMD_ERR <= 1'b1;
                    end
                    if (!bus.TX_BUSY) begin
                        bus.TX_D_VLD <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: directed test-plan cases plus random command mixes, checked as
// time-stamped output events against a transaction-level model with its own register image.
module tb_reg_cmd_ctrl;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int EV_W   = 47;
    localparam logic [2:0] EV_WR  = 3'd0;
    localparam logic [2:0] EV_RD  = 3'd1;
    localparam logic [2:0] EV_TX  = 3'd2;
    localparam logic [2:0] EV_ERR = 3'd3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    reg_cmd_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_cmd_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .RD_TIMEOUT(4)
    ) dut (
        .CLK(clk),
        .RST_n(rst_n),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // scoreboard state
    logic [EV_W-1:0] exp_q[$];
    logic [EV_W-1:0] obs_q[$];
    logic [7:0]      ref_mem[DEPTH];
    logic [7:0]      rf_mem[DEPTH];
    logic            overlap_seen = 1'b0;
    logic            rf_respond   = 1'b1;
    int              busy_until   = 0;
    int              n_checks     = 0;
    int              n_fail       = 0;

    function automatic logic [EV_W-1:0] ev(input int stamp, input logic [2:0] kind,
                                           input logic [3:0] a, input logic [7:0] d);
        return {32'(stamp), kind, a, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: every output strobe becomes a time-stamped event
    always @(negedge clk) begin
        if (bus.WrEn)     obs_q.push_back(ev(edge_cnt, EV_WR, bus.Address, bus.WrData));
        if (bus.RdEn)     obs_q.push_back(ev(edge_cnt, EV_RD, bus.Address, 8'h00));
        if (bus.TX_D_VLD) obs_q.push_back(ev(edge_cnt, EV_TX, 4'h0, bus.TX_P_DATA));
        if (bus.CMD_ERR)  obs_q.push_back(ev(edge_cnt, EV_ERR, 4'h0, 8'h00));
        if (bus.WrEn && bus.RdEn) overlap_seen = 1'b1;
    end

    // register-file and transmitter responders (1-cycle read latency, regs 2/3 read-only)
    logic       rd_pend = 1'b0;
    logic [3:0] rd_addr = '0;
    always @(negedge clk) begin
        bus.RdData_Valid = 1'b0;
        if (rd_pend && rf_respond) begin
            bus.RdData_Valid = 1'b1;
            bus.RdData       = rf_mem[rd_addr];
        end
        rd_pend = bus.RdEn;
        rd_addr = bus.Address;
        if (bus.WrEn && bus.Address != 4'd2 && bus.Address != 4'd3)
            rf_mem[bus.Address] = bus.WrData;
        bus.TX_BUSY = (edge_cnt + 1 < busy_until);
    end

    // driver tasks (always entered at a negedge)
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int e);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        e = edge_cnt + 1;
        @(negedge clk);
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int max_gap);
        int e;
        send_byte(8'hAA, e);
        idle($urandom_range(0, max_gap));
        send_byte(a, e);
        if (a[7:4] != 4'h0) begin
            exp_q.push_back(ev(e, EV_ERR, 4'h0, 8'h00));
        end else begin
            idle($urandom_range(0, max_gap));
            send_byte(d, e);
            exp_q.push_back(ev(e, EV_WR, a[3:0], d));
            if (a[3:0] != 4'd2 && a[3:0] != 4'd3) ref_mem[a[3:0]] = d;
        end
    endtask

    task automatic do_read(input logic [7:0] a, input int bc, input logic respond,
                           input logic drop, input int max_gap);
        int e, e1, ed, t;
        rf_respond = respond;
        send_byte(8'hBB, e);
        idle($urandom_range(0, max_gap));
        send_byte(a, e1);
        if (a[7:4] != 4'h0) begin
            exp_q.push_back(ev(e1, EV_ERR, 4'h0, 8'h00));
        end else begin
            busy_until = e1 + 2 + bc;
            exp_q.push_back(ev(e1, EV_RD, a[3:0], 8'h00));
            if (drop) begin
                send_byte(8'($urandom), ed);
                exp_q.push_back(ev(ed, EV_ERR, 4'h0, 8'h00));
                if (respond && bc >= 3) begin
                    idle(1);
                    send_byte(8'($urandom), ed);
                    exp_q.push_back(ev(ed, EV_ERR, 4'h0, 8'h00));
                end
            end
            if (!respond) begin
                exp_q.push_back(ev(e1 + 5, EV_ERR, 4'h0, 8'h00));
            end else begin
                t = (busy_until > e1 + 2) ? busy_until : e1 + 2;
                exp_q.push_back(ev(t, EV_TX, 4'h0, ref_mem[a[3:0]]));
            end
        end
        idle(bc + 10);
        rf_respond = 1'b1;
    endtask

    task automatic do_bad_op(input logic [7:0] b);
        int e;
        send_byte(b, e);
        exp_q.push_back(ev(e, EV_ERR, 4'h0, 8'h00));
    endtask

    task automatic compare_events(input string tag);
        exp_q.sort();
        obs_q.sort();
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, obs_q[i], exp_q[i]);
        check({tag, "_overlap"}, overlap_seen, 0);
        exp_q.delete();
        obs_q.delete();
        overlap_seen = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"},    bus.WrEn,      0);
        check({tag, "_rden"},    bus.RdEn,      0);
        check({tag, "_addr"},    bus.Address,   0);
        check({tag, "_wrdata"},  bus.WrData,    0);
        check({tag, "_txdata"},  bus.TX_P_DATA, 0);
        check({tag, "_txvld"},   bus.TX_D_VLD,  0);
        check({tag, "_cmderr"},  bus.CMD_ERR,   0);
    endtask

    initial begin
        int e, e1, kind;
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 8'(i * 37 + 5);
            rf_mem[i]  = 8'(i * 37 + 5);
        end
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'h00;

        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // directed test plan
        do_write(8'h07, 8'h46, 0);
        idle(4);
        compare_events("write_07");
        do_read(8'h07, 0, 1'b1, 1'b0, 0);
        compare_events("read_07");
        do_read(8'h07, 10, 1'b1, 1'b0, 0);
        compare_events("read_busy");
        do_bad_op(8'h55);
        idle(4);
        compare_events("bad_op_55");
        do_write(8'h1F, 8'h00, 0);
        idle(4);
        compare_events("bad_addr_1f");
        do_read(8'h03, 0, 1'b0, 1'b0, 0);
        compare_events("rd_timeout");

        // reset in the middle of a write command
        send_byte(8'hAA, e);
        send_byte(8'h05, e);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check_outputs_zero("mid_reset");
        do_bad_op(8'h33);
        idle(6);
        compare_events("post_reset");

        // back-to-back write then read of the same register
        send_byte(8'hAA, e);
        send_byte(8'h09, e);
        send_byte(8'h5A, e);
        exp_q.push_back(ev(e, EV_WR, 4'h9, 8'h5A));
        ref_mem[9] = 8'h5A;
        send_byte(8'hBB, e);
        send_byte(8'h09, e1);
        exp_q.push_back(ev(e1, EV_RD, 4'h9, 8'h00));
        exp_q.push_back(ev(e1 + 2, EV_TX, 4'h0, 8'h5A));
        idle(10);
        check("b2b_txdata", bus.TX_P_DATA, 8'h5A);
        compare_events("b2b");

        // randomized command mix
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: do_write(8'($urandom_range(0, 15)), 8'($urandom), 2);
                2:    do_read(8'($urandom_range(0, 15)), $urandom_range(0, 4), 1'b1, 1'b0, 2);
                3:    do_read(8'($urandom_range(0, 15)), $urandom_range(0, 5), 1'b1, 1'b1, 2);
                4: begin
                    if ($urandom_range(0, 1) == 0) begin
                        do
                            b = 8'($urandom);
                        while (b == 8'hAA || b == 8'hBB);
                        do_bad_op(b);
                    end else if ($urandom_range(0, 1) == 0) begin
                        do_write(8'($urandom_range(16, 255)), 8'($urandom), 2);
                    end else begin
                        do_read(8'($urandom_range(16, 255)), 0, 1'b1, 1'b0, 2);
                    end
                end
                default: do_read(8'($urandom_range(0, 15)), 0, 1'b0, $urandom_range(0, 1) == 1, 2);
            endcase
            idle($urandom_range(3, 6));
            compare_events("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
